// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller.
//   game_state_t  : encoded controller state, as seen on the game_state port
//   PU_IMMORTAL   : power-up channel that blocks player hits
//   PU_SUPER_ROPE : power-up channel that keeps the rope alive at the ceiling
package game_pkg;

    typedef enum logic [2:0] {
        WELCOME     = 3'd0,
        PLAY        = 3'd1,
        PAUSE       = 3'd2,
        LEVEL_CLEAR = 3'd3,
        GAME_OVER   = 3'd4
    } game_state_t;

    localparam int PU_IMMORTAL   = 0;
    localparam int PU_SUPER_ROPE = 1;

endpackage

// File: rtl/powerup_timer.sv
// One power-up channel: a seconds countdown with an active flag.
//   clk, reset : clock, synchronous active-high reset
//   clear      : drop the power-up immediately (level end / outside a game)
//   load       : (re)start the channel with 'duration' seconds
//   duration   : seconds to load
//   tick       : one-cycle pulse per second
//   freeze     : ignore ticks (game paused)
//   active     : channel currently in effect
// A tick at a count of zero ends the power-up, so a channel stays active
// for duration+1 ticks after loading. Load wins over a same-cycle tick.
module powerup_timer #(
    parameter int TIMER_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [TIMER_W-1:0] duration,
    input  logic               tick,
    input  logic               freeze,
    output logic               active
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= duration;
            active <= 1'b1;
        end else if (tick && !freeze && active) begin
            if (count != '0)
                count <= count - TIMER_W'(1);
            else
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Game-flow controller: welcome / play / pause / level-clear / game-over
// sequencing, lives, saturating score with persistent high score, rope
// control and N power-up channels.
//   Inputs : clk, reset (sync, active-high), start_key/pause_key (edge used),
//            fire_key, right_key, left_key, sec_tick, collision pulses
//            (col_player_ball, col_rope_ball + col_ball_type, col_present +
//            present_type), rope_at_top, balls_cleared
//   Outputs: game_state, level, lives, score, max_score, powerup_active,
//            player/rope controls, pulses player_reset/rope_fire/level_load,
//            game_won (sticky until WELCOME). All outputs are registered.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int N_POWERUPS      = 3,
    parameter int TIMER_W         = 4,
    parameter int PU_DURATION     = 5,
    parameter int HIT_IMMUNITY    = 3,
    parameter int LIVES_W         = 3,
    parameter int INITIAL_LIVES   = 3,
    parameter int MAX_LIVES       = 4,
    parameter int N_LEVELS        = 4,
    parameter int LEVEL_PAUSE_SEC = 2,
    parameter int SCORE_W         = 16,
    parameter int HIT_SCORE       = 10,
    parameter int BALL_TYPE_W     = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_key,
    input  logic                              pause_key,
    input  logic                              fire_key,
    input  logic                              right_key,
    input  logic                              left_key,
    input  logic                              sec_tick,
    input  logic                              col_player_ball,
    input  logic                              col_rope_ball,
    input  logic [BALL_TYPE_W-1:0]            col_ball_type,
    input  logic                              col_present,
    input  logic [$clog2(N_POWERUPS+1)-1:0]   present_type,
    input  logic                              rope_at_top,
    input  logic                              balls_cleared,
    output logic [2:0]                        game_state,
    output logic [$clog2(N_LEVELS)-1:0]       level,
    output logic [LIVES_W-1:0]                lives,
    output logic [SCORE_W-1:0]                score,
    output logic [SCORE_W-1:0]                max_score,
    output logic [N_POWERUPS-1:0]             powerup_active,
    output logic                              player_move_r,
    output logic                              player_move_l,
    output logic                              player_visible,
    output logic                              rope_active,
    output logic                              playmode_enable,
    output logic                              player_reset,
    output logic                              rope_fire,
    output logic                              level_load,
    output logic                              game_won
);

    localparam int LEVEL_W = $clog2(N_LEVELS);
    localparam int PT_W    = $clog2(N_POWERUPS + 1);
    localparam int CLR_W   = $clog2(LEVEL_PAUSE_SEC + 1);
    localparam int SUM_W   = SCORE_W + 2;
    localparam int SR_IDX  = (N_POWERUPS > 1) ? PU_SUPER_ROPE : PU_IMMORTAL;

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INITIAL_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_MAX  = LIVES_W'(MAX_LIVES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(N_LEVELS - 1);
    localparam logic [CLR_W-1:0]   CLR_LAST   = CLR_W'(LEVEL_PAUSE_SEC - 1);
    localparam logic [SUM_W-1:0]   SCORE_SAT  = {2'b00, {SCORE_W{1'b1}}};
    localparam logic [TIMER_W-1:0] PU_DUR     = TIMER_W'(PU_DURATION);
    localparam logic [TIMER_W-1:0] IMM_DUR    = TIMER_W'(HIT_IMMUNITY);

    game_state_t        state, state_n;
    logic               start_prev, pause_prev, start_edge, pause_edge;
    logic [LEVEL_W-1:0] level_n;
    logic [LIVES_W-1:0] lives_n;
    logic [SCORE_W-1:0] score_n;
    logic [CLR_W-1:0]   clr_cnt, clr_cnt_n;
    logic [SUM_W-1:0]   sum, hit_pts;
    logic               rope_n, rope_fire_n, level_load_n, player_reset_n, game_won_n;
    logic               hit_eff, extra_life, super_rope;

    assign start_edge = start_key & ~start_prev;
    assign pause_edge = pause_key & ~pause_prev;
    assign game_state = state;
    assign super_rope = (N_POWERUPS > 1) && powerup_active[SR_IDX];
    assign hit_pts    = SUM_W'(HIT_SCORE) * (SUM_W'(col_ball_type) + SUM_W'(1));

    always_comb begin
        state_n        = state;
        level_n        = level;
        lives_n        = lives;
        score_n        = score;
        clr_cnt_n      = clr_cnt;
        rope_n         = 1'b0;
        rope_fire_n    = 1'b0;
        level_load_n   = 1'b0;
        player_reset_n = 1'b0;
        game_won_n     = game_won;
        hit_eff        = 1'b0;
        extra_life     = 1'b0;
        sum            = '0;
        case (state)
            WELCOME: begin
                if (start_edge) begin
                    state_n      = PLAY;
                    level_n      = '0;
                    lives_n      = LIVES_INIT;
                    score_n      = '0;
                    level_load_n = 1'b1;
                end
            end
            PLAY: begin
                hit_eff    = col_player_ball && !powerup_active[PU_IMMORTAL];
                extra_life = col_present && (present_type == '0);
                // Sum in two extra bits so tick + largest hit cannot wrap before saturating.
                sum = {2'b00, score} + SUM_W'(sec_tick) + (col_rope_ball ? hit_pts : '0);
                score_n = (sum > SCORE_SAT) ? '1 : sum[SCORE_W-1:0];
                if (hit_eff && extra_life)
                    lives_n = lives;
                else if (hit_eff)
                    lives_n = (lives != '0) ? lives - LIVES_W'(1) : '0;
                else if (extra_life && lives < LIVES_MAX)
                    lives_n = lives + LIVES_W'(1);
                player_reset_n = hit_eff;
                if (rope_active)
                    rope_n = !(col_rope_ball || (rope_at_top && !super_rope));
                else if (fire_key) begin
                    rope_n      = 1'b1;
                    rope_fire_n = 1'b1;
                end
                if (lives_n == '0) begin
                    state_n = GAME_OVER;
                    rope_n  = 1'b0;
                end else if (balls_cleared) begin
                    state_n   = LEVEL_CLEAR;
                    clr_cnt_n = '0;
                    rope_n    = 1'b0;
                end else if (pause_edge) begin
                    state_n = PAUSE;
                    rope_n  = 1'b0;
                end
            end
            PAUSE: begin
                if (pause_edge)
                    state_n = PLAY;
            end
            LEVEL_CLEAR: begin
                if (sec_tick) begin
                    if (clr_cnt == CLR_LAST) begin
                        if (level < LAST_LEVEL) begin
                            state_n      = PLAY;
                            level_n      = level + LEVEL_W'(1);
                            level_load_n = 1'b1;
                        end else begin
                            state_n    = GAME_OVER;
                            game_won_n = 1'b1;
                        end
                    end else begin
                        clr_cnt_n = clr_cnt + CLR_W'(1);
                    end
                end
            end
            GAME_OVER: begin
                if (start_edge) begin
                    state_n    = WELCOME;
                    game_won_n = 1'b0;
                end
            end
            default: state_n = WELCOME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= WELCOME;
            level           <= '0;
            lives           <= LIVES_INIT;
            score           <= '0;
            max_score       <= '0;
            clr_cnt         <= '0;
            start_prev      <= 1'b0;
            pause_prev      <= 1'b0;
            rope_active     <= 1'b0;
            rope_fire       <= 1'b0;
            level_load      <= 1'b0;
            player_reset    <= 1'b0;
            game_won        <= 1'b0;
            playmode_enable <= 1'b0;
            player_visible  <= 1'b0;
            player_move_r   <= 1'b0;
            player_move_l   <= 1'b0;
        end else begin
            state           <= state_n;
            level           <= level_n;
            lives           <= lives_n;
            score           <= score_n;
            if (score_n > max_score)
                max_score <= score_n;
            clr_cnt         <= clr_cnt_n;
            start_prev      <= start_key;
            pause_prev      <= pause_key;
            rope_active     <= rope_n;
            rope_fire       <= rope_fire_n;
            level_load      <= level_load_n;
            player_reset    <= player_reset_n;
            game_won        <= game_won_n;
            playmode_enable <= (state_n == PLAY);
            player_visible  <= (state_n == PLAY) || (state_n == PAUSE);
            player_move_r   <= (state == PLAY) && (state_n == PLAY) && right_key;
            player_move_l   <= (state == PLAY) && (state_n == PLAY) && left_key;
        end
    end

    // Channels are cleared on the same edge the game leaves PLAY/PAUSE, so
    // nothing carries into LEVEL_CLEAR, GAME_OVER or the next game.
    for (genvar k = 0; k < N_POWERUPS; k++) begin : g_pu
        logic               pick, load;
        logic [TIMER_W-1:0] dur;
        assign pick = col_present && (present_type == PT_W'(k + 1));
        assign load = ((state == PLAY) && pick) || ((k == PU_IMMORTAL) && hit_eff);
        assign dur  = pick ? PU_DUR : IMM_DUR;
        powerup_timer #(.TIMER_W(TIMER_W)) u_timer (
            .clk      (clk),
            .reset    (reset),
            .clear    ((state_n != PLAY) && (state_n != PAUSE)),
            .load     (load),
            .duration (dur),
            .tick     (sec_tick),
            .freeze   (state != PLAY),
            .active   (powerup_active[k])
        );
    end

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;

    localparam logic [2:0] S_WELCOME = 3'd0, S_PLAY = 3'd1, S_PAUSE = 3'd2,
                           S_LCLEAR = 3'd3, S_OVER = 3'd4;
    localparam int IMM = 3, PUD = 5, MAXL = 4, SMAX = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_key, pause_key, fire_key, right_key, left_key, sec_tick;
    logic col_player_ball, col_rope_ball, col_present, rope_at_top, balls_cleared;
    logic [1:0] col_ball_type, present_type;
    logic [2:0] game_state;
    logic [1:0] level;
    logic [2:0] lives;
    logic [15:0] score, max_score;
    logic [2:0] powerup_active;
    logic player_move_r, player_move_l, player_visible, rope_active, playmode_enable;
    logic player_reset, rope_fire, level_load, game_won;

    int n_checks = 0;
    int n_fail   = 0;

    game_flow_controller dut (
        .clk(clk), .reset(reset), .start_key(start_key), .pause_key(pause_key),
        .fire_key(fire_key), .right_key(right_key), .left_key(left_key), .sec_tick(sec_tick),
        .col_player_ball(col_player_ball), .col_rope_ball(col_rope_ball),
        .col_ball_type(col_ball_type), .col_present(col_present), .present_type(present_type),
        .rope_at_top(rope_at_top), .balls_cleared(balls_cleared), .game_state(game_state),
        .level(level), .lives(lives), .score(score), .max_score(max_score),
        .powerup_active(powerup_active), .player_move_r(player_move_r),
        .player_move_l(player_move_l), .player_visible(player_visible),
        .rope_active(rope_active), .playmode_enable(playmode_enable),
        .player_reset(player_reset), .rope_fire(rope_fire), .level_load(level_load),
        .game_won(game_won)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_key = 0; pause_key = 0; fire_key = 0; right_key = 0; left_key = 0;
        sec_tick = 0; col_player_ball = 0; col_rope_ball = 0; col_ball_type = 0;
        col_present = 0; present_type = 0; rope_at_top = 0; balls_cleared = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1; step(); step(); reset = 0;
    endtask

    task automatic start_game();
        start_key = 1; step(); start_key = 0; step();
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 0; start_key = 1; step(); fire_key = 1; sec_tick = 1; step();
        do_reset();
        n_checks++; if (game_state !== S_WELCOME) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", game_state, S_WELCOME); end
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", lives); end
        n_checks++; if (score !== 16'd0 || max_score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d/%0d want 0/0", score, max_score); end
        n_checks++; if (powerup_active !== 3'b000) begin n_fail++; $display("FAIL reset_pu: got %b want 000", powerup_active); end
        n_checks++; if ({rope_active, rope_fire, level_load, player_reset, game_won, playmode_enable} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000000", {rope_active, rope_fire, level_load, player_reset, game_won, playmode_enable}); end
    endtask

    task automatic test_start();
        do_reset();
        start_key = 1; step(); start_key = 0;
        n_checks++; if (game_state !== S_PLAY) begin n_fail++; $display("FAIL start_state: got %0d want %0d", game_state, S_PLAY); end
        n_checks++; if (level_load !== 1'b1) begin n_fail++; $display("FAIL start_load: got %b want 1", level_load); end
        n_checks++; if (lives !== 3'd3 || score !== 16'd0) begin n_fail++; $display("FAIL start_vals: got lives %0d score %0d want 3 0", lives, score); end
        n_checks++; if (playmode_enable !== 1'b1 || player_visible !== 1'b1) begin n_fail++; $display("FAIL start_play: got %b%b want 11", playmode_enable, player_visible); end
        step();
        n_checks++; if (level_load !== 1'b0) begin n_fail++; $display("FAIL start_load_pulse: got %b want 0", level_load); end
    endtask

    task automatic test_score();
        int exp_score;
        int t, h, ty;
        do_reset(); start_game();
        col_rope_ball = 1; col_ball_type = 2; sec_tick = 1; step(); clear_inputs();
        exp_score = 31;
        n_checks++; if (score !== 16'(exp_score) || max_score !== 16'(exp_score)) begin
            n_fail++; $display("FAIL score_tick_hit: got %0d/%0d want %0d", score, max_score, exp_score); end
        for (int i = 0; i < 60; i++) begin
            t = $urandom_range(0, 1); h = $urandom_range(0, 1); ty = $urandom_range(0, 3);
            sec_tick = t[0]; col_rope_ball = h[0]; col_ball_type = ty[1:0];
            step(); clear_inputs();
            exp_score = exp_score + t + (h * 10 * (ty + 1));
            n_checks++; if (score !== 16'(exp_score) || max_score !== 16'(exp_score)) begin
                n_fail++; $display("FAIL score_rand: got %0d/%0d want %0d", score, max_score, exp_score); end
        end
        for (int i = 0; i < 1700; i++) begin
            sec_tick = 1; col_rope_ball = 1; col_ball_type = 3;
            step(); clear_inputs();
            exp_score = exp_score + 41;
            if (exp_score > SMAX) exp_score = SMAX;
            n_checks++; if (score !== 16'(exp_score)) begin n_fail++; $display("FAIL score_sat_run: got %0d want %0d", score, exp_score); end
        end
        n_checks++; if (score !== 16'hFFFF || max_score !== 16'hFFFF) begin
            n_fail++; $display("FAIL score_saturated: got %0d/%0d want 65535", score, max_score); end
    endtask

    task automatic test_player_hit();
        int exp_lives, since;
        logic hit;
        do_reset(); start_game();
        col_player_ball = 1; step(); clear_inputs();
        exp_lives = 2; since = 0;
        n_checks++; if (lives !== 3'(exp_lives) || player_reset !== 1'b1 || powerup_active[0] !== 1'b1) begin
            n_fail++; $display("FAIL hit_first: got lives %0d rst %b imm %b want 2 1 1", lives, player_reset, powerup_active[0]); end
        step();
        n_checks++; if (player_reset !== 1'b0) begin n_fail++; $display("FAIL hit_pulse: got %b want 0", player_reset); end
        for (int t = 1; t <= 4; t++) begin
            idle_gap();
            hit = 1'($urandom_range(0, 1));
            col_player_ball = hit; sec_tick = 1; step(); clear_inputs();
            if (hit && since > IMM) exp_lives--;
            since++;
            n_checks++; if (lives !== 3'(exp_lives) || powerup_active[0] !== (since <= IMM)) begin
                n_fail++; $display("FAIL hit_immunity: tick %0d got lives %0d imm %b want %0d %b", t, lives, powerup_active[0], exp_lives, since <= IMM); end
        end
        col_player_ball = 1; step(); clear_inputs();
        exp_lives--;
        n_checks++; if (lives !== 3'(exp_lives) || powerup_active[0] !== 1'b1) begin
            n_fail++; $display("FAIL hit_second: got lives %0d imm %b want %0d 1", lives, powerup_active[0], exp_lives); end
        for (int t = 0; t < 4; t++) begin sec_tick = 1; step(); clear_inputs(); end
        col_player_ball = 1; col_present = 1; present_type = 0; step(); clear_inputs();
        n_checks++; if (lives !== 3'(exp_lives) || player_reset !== 1'b1) begin
            n_fail++; $display("FAIL hit_plus_life: got lives %0d rst %b want %0d 1", lives, player_reset, exp_lives); end
        for (int i = 0; i < 4; i++) begin
            idle_gap();
            col_present = 1; present_type = 0; step(); clear_inputs();
            if (exp_lives < MAXL) exp_lives++;
            n_checks++; if (lives !== 3'(exp_lives)) begin n_fail++; $display("FAIL extra_life: got %0d want %0d", lives, exp_lives); end
        end
    endtask

    task automatic test_powerup();
        int since, exp_score;
        do_reset(); start_game();
        exp_score = 0;
        col_present = 1; present_type = 2; step(); clear_inputs();
        since = 0;
        n_checks++; if (powerup_active !== 3'b010) begin n_fail++; $display("FAIL pu_collect: got %b want 010", powerup_active); end
        for (int t = 0; t < 3; t++) begin
            idle_gap(); sec_tick = 1; step(); clear_inputs();
            since++; exp_score++;
            n_checks++; if (powerup_active[1] !== (since <= PUD)) begin n_fail++; $display("FAIL pu_run: got %b want %b", powerup_active[1], since <= PUD); end
        end
        col_present = 1; present_type = 2; sec_tick = 1; step(); clear_inputs();
        since = 0; exp_score++;
        pause_key = 1; step(); pause_key = 0;
        n_checks++; if (game_state !== S_PAUSE || player_visible !== 1'b1) begin
            n_fail++; $display("FAIL pause_enter: got %0d vis %b want %0d 1", game_state, player_visible, S_PAUSE); end
        for (int i = 0; i < 10; i++) begin
            sec_tick = 1; right_key = 1; col_present = 1; present_type = 3;
            col_player_ball = 1; col_rope_ball = 1; fire_key = 1;
            step(); clear_inputs();
            n_checks++; if (powerup_active !== 3'b010 || player_move_r !== 1'b0 || score !== 16'(exp_score) || lives !== 3'd3) begin
                n_fail++; $display("FAIL pause_frozen: got pu %b mv %b score %0d lives %0d want 010 0 %0d 3", powerup_active, player_move_r, score, lives, exp_score); end
        end
        pause_key = 1; step(); pause_key = 0;
        n_checks++; if (game_state !== S_PLAY) begin n_fail++; $display("FAIL pause_exit: got %0d want %0d", game_state, S_PLAY); end
        right_key = 1; step(); right_key = 0;
        n_checks++; if (player_move_r !== 1'b1) begin n_fail++; $display("FAIL move_r: got %b want 1", player_move_r); end
        for (int t = 0; t < 6; t++) begin
            idle_gap(); sec_tick = 1; step(); clear_inputs();
            since++;
            n_checks++; if (powerup_active[1] !== (since <= PUD)) begin
                n_fail++; $display("FAIL pu_restart: tick %0d got %b want %b", since, powerup_active[1], since <= PUD); end
        end
    endtask

    task automatic test_rope();
        do_reset(); start_game();
        fire_key = 1; step(); fire_key = 0;
        n_checks++; if (rope_active !== 1'b1 || rope_fire !== 1'b1) begin n_fail++; $display("FAIL rope_fire: got %b%b want 11", rope_active, rope_fire); end
        fire_key = 1; step(); fire_key = 0;
        n_checks++; if (rope_active !== 1'b1 || rope_fire !== 1'b0) begin n_fail++; $display("FAIL rope_refire: got %b%b want 10", rope_active, rope_fire); end
        rope_at_top = 1; step(); rope_at_top = 0;
        n_checks++; if (rope_active !== 1'b0) begin n_fail++; $display("FAIL rope_top: got %b want 0", rope_active); end
        fire_key = 1; step(); fire_key = 0;
        col_rope_ball = 1; step(); col_rope_ball = 0;
        n_checks++; if (rope_active !== 1'b0 || score !== 16'd10) begin n_fail++; $display("FAIL rope_hit: got %b score %0d want 0 10", rope_active, score); end
        col_present = 1; present_type = 2; step(); clear_inputs();
        fire_key = 1; step(); fire_key = 0;
        rope_at_top = 1; step(); step(); rope_at_top = 0;
        n_checks++; if (rope_active !== 1'b1) begin n_fail++; $display("FAIL rope_super: got %b want 1", rope_active); end
    endtask

    task automatic test_levels();
        do_reset(); start_game();
        for (int lvl = 0; lvl < 4; lvl++) begin
            col_present = 1; present_type = 2; fire_key = 1; step(); clear_inputs();
            idle_gap();
            balls_cleared = 1; step(); balls_cleared = 0;
            n_checks++; if (game_state !== S_LCLEAR || player_visible !== 1'b0 || rope_active !== 1'b0 || powerup_active !== 3'b000) begin
                n_fail++; $display("FAIL lclear_enter: got st %0d vis %b rope %b pu %b want %0d 0 0 000", game_state, player_visible, rope_active, powerup_active, S_LCLEAR); end
            for (int t = 1; t <= 2; t++) begin
                idle_gap(); sec_tick = 1; step(); sec_tick = 0;
                if (t < 2) begin
                    n_checks++; if (game_state !== S_LCLEAR) begin n_fail++; $display("FAIL lclear_wait: got %0d want %0d", game_state, S_LCLEAR); end
                end else if (lvl < 3) begin
                    n_checks++; if (game_state !== S_PLAY || level !== 2'(lvl + 1) || level_load !== 1'b1) begin
                        n_fail++; $display("FAIL level_next: got st %0d lvl %0d load %b want %0d %0d 1", game_state, level, level_load, S_PLAY, lvl + 1); end
                end else begin
                    n_checks++; if (game_state !== S_OVER || game_won !== 1'b1) begin
                        n_fail++; $display("FAIL game_win: got st %0d won %b want %0d 1", game_state, game_won, S_OVER); end
                end
            end
        end
        step(); step();
        n_checks++; if (game_won !== 1'b1) begin n_fail++; $display("FAIL won_sticky: got %b want 1", game_won); end
        start_key = 1; step(); start_key = 0;
        n_checks++; if (game_state !== S_WELCOME || game_won !== 1'b0) begin
            n_fail++; $display("FAIL won_clear: got st %0d won %b want %0d 0", game_state, game_won, S_WELCOME); end
    endtask

    task automatic test_game_over();
        int exp_score, exp_lives, h, ty;
        do_reset(); start_game();
        exp_score = 0; exp_lives = 3;
        for (int i = 0; i < 8; i++) begin
            h = $urandom_range(0, 1); ty = $urandom_range(0, 3);
            col_rope_ball = h[0]; col_ball_type = ty[1:0]; step(); clear_inputs();
            exp_score = exp_score + h * 10 * (ty + 1);
        end
        for (int i = 0; i < 3; i++) begin
            col_player_ball = 1; step(); clear_inputs();
            exp_lives--;
            if (exp_lives > 0) begin
                n_checks++; if (game_state !== S_PLAY || lives !== 3'(exp_lives)) begin
                    n_fail++; $display("FAIL lose_life: got st %0d lives %0d want %0d %0d", game_state, lives, S_PLAY, exp_lives); end
                for (int t = 0; t < 4; t++) begin sec_tick = 1; step(); clear_inputs(); exp_score++; end
            end else begin
                n_checks++; if (game_state !== S_OVER || lives !== 3'd0 || game_won !== 1'b0) begin
                    n_fail++; $display("FAIL game_over: got st %0d lives %0d won %b want %0d 0 0", game_state, lives, game_won, S_OVER); end
            end
        end
        n_checks++; if (max_score !== 16'(exp_score)) begin n_fail++; $display("FAIL max_at_over: got %0d want %0d", max_score, exp_score); end
        start_key = 1; step(); start_key = 0; step();
        n_checks++; if (game_state !== S_WELCOME || max_score !== 16'(exp_score)) begin
            n_fail++; $display("FAIL over_welcome: got st %0d max %0d want %0d %0d", game_state, max_score, S_WELCOME, exp_score); end
        start_key = 1; step(); start_key = 0;
        n_checks++; if (game_state !== S_PLAY || score !== 16'd0 || max_score !== 16'(exp_score) || lives !== 3'd3) begin
            n_fail++; $display("FAIL new_game: got st %0d score %0d max %0d lives %0d want %0d 0 %0d 3", game_state, score, max_score, lives, S_PLAY, exp_score); end
        fire_key = 1; col_present = 1; present_type = 1; sec_tick = 1; step(); clear_inputs();
        col_player_ball = 1; step(); clear_inputs();
        reset = 1; step(); reset = 0;
        n_checks++; if (game_state !== S_WELCOME || lives !== 3'd3 || score !== 16'd0 || max_score !== 16'd0 || powerup_active !== 3'b000 || rope_active !== 1'b0 || playmode_enable !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got st %0d lives %0d score %0d max %0d pu %b rope %b pm %b", game_state, lives, score, max_score, powerup_active, rope_active, playmode_enable); end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_start();
        test_score();
        test_player_hit();
        test_powerup();
        test_rope();
        test_levels();
        test_game_over();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
